ps2_command_arbiter: RTL

Shares the single PS/2 host-to-keyboard command channel between several requesters, such as the LED updater, the typematic-rate setter and the keyboard-reset logic. Each granted request is a one- or two-byte keyboard command. For every byte the block sequences four steps: send the byte, wait for the line-level transmit acknowledge, wait for the keyboard's 0xFA reply, then move on. It resends on 0xFE, a line error or a timeout, up to a retry limit, and reports completion or failure to the owning requester. It sits between the requesters and the PS/2 transmitter, and observes reply bytes from the scan-code receive path.

---
 rtl/ps2_command_arbiter_if.sv | 20 ++
 rtl/ps2_command_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/ps2_command_arbiter_if.sv
// ps2_command_arbiter_if: requester, PS/2 transmitter and reply-path signals of the command arbiter.
interface ps2_command_arbiter_if #(parameter int N = 2);
   logic [N-1:0] req_valid, req_two_bytes, req_ready, req_done;
   logic [16*N-1:0] req_bytes;
   logic req_error, command_valid, command_ready, command_ack_ready;
   logic command_ack_valid, command_ack_error, response_valid, busy;
   logic [7:0] command_byte, response_byte;
   modport master (
      input req_valid, req_two_bytes, req_bytes, command_ready, command_ack_valid,
            command_ack_error, response_valid, response_byte,
      output req_ready, req_done, req_error, command_valid, command_byte,
             command_ack_ready, busy
   );
   modport slave (
      output req_valid, req_two_bytes, req_bytes, command_ready, command_ack_valid,
             command_ack_error, response_valid, response_byte,
      input req_ready, req_done, req_error, command_valid, command_byte,
            command_ack_ready, busy
   );
endinterface

// File: rtl/ps2_command_arbiter.sv
// ps2_command_arbiter: round-robin owner of the PS/2 host-to-keyboard command channel with per-byte ack, reply and resend.
module ps2_command_arbiter #(
   parameter int REQUESTERS = 2,
   parameter int RETRIES = 3,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input logic clk,
   input logic reset,
   ps2_command_arbiter_if.master bus
);
   localparam int N = REQUESTERS;
   localparam int GW = N > 1 ? $clog2(N) : 1;
   localparam int RW = RETRIES > 0 ? $clog2(RETRIES + 1) : 1;
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, SEND, LINE_ACK, REPLY} state_t;
   state_t st, nxt;
   logic [GW-1:0] g, pick, idx;
   logic [RW-1:0] r;
   logic [TW-1:0] timer;
   logic [7:0] b0, b1;
   logic [N-1:0] done_q;
   logic k, two, err_q, any, retry, fail, done_ok, advance;
   logic tmo, ack_ok, fa, fe;
   assign ack_ok = bus.command_ack_valid && !bus.command_ack_error;
   assign fa = bus.response_valid && bus.response_byte == 8'hFA;
   assign fe = bus.response_valid && bus.response_byte == 8'hFE;
   assign tmo = timer >= TW'(TIMEOUT_CYCLES - 1);
   // Scanning downward lets the nearest requester after g overwrite the rest.
   always_comb begin
      pick = g;
      any = 1'b0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = GW'((int'(g) + i) % N);
         if (bus.req_valid[idx]) begin
            pick = idx;
            any = 1'b1;
         end
      end
   end
   always_comb begin
      nxt = st;
      retry = 1'b0;
      done_ok = 1'b0;
      advance = 1'b0;
      case (st)
         IDLE: nxt = any ? SEND : IDLE;
         SEND: nxt = bus.command_ready ? LINE_ACK : SEND;
         LINE_ACK: begin
            retry = bus.command_ack_valid ? bus.command_ack_error : tmo;
            nxt = ack_ok ? REPLY : LINE_ACK;
         end
         REPLY: begin
            done_ok = fa && k == two;
            advance = fa && k != two;
            retry = fe || (!fa && tmo);
            nxt = done_ok ? IDLE : advance ? SEND : REPLY;
         end
         default: nxt = IDLE;
      endcase
      fail = retry && r == RW'(RETRIES);
      if (retry) nxt = fail ? IDLE : SEND;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= IDLE;
         g <= GW'(N - 1);
         r <= '0;
         k <= 1'b0;
         timer <= '0;
         b0 <= '0;
         b1 <= '0;
         two <= 1'b0;
         done_q <= '0;
         err_q <= 1'b0;
      end else begin
         st <= nxt;
         timer <= ((st == LINE_ACK && !ack_ok) || st == REPLY) ? (&timer ? timer : timer + 1'b1) : '0;
         done_q <= (done_ok || fail) ? N'(1) << g : '0;
         err_q <= fail;
         if (st == IDLE && any) begin
            g <= pick;
            b0 <= bus.req_bytes[16*int'(pick) +: 8];
            b1 <= bus.req_bytes[16*int'(pick) + 8 +: 8];
            two <= bus.req_two_bytes[pick];
            k <= 1'b0;
            r <= '0;
         end
         if (retry && !fail) r <= r + 1'b1;
         if (advance) k <= 1'b1;
      end
   end
   always_comb begin
      bus.req_ready = (st == IDLE && any && !reset) ? N'(1) << pick : '0;
      bus.req_done = done_q;
      bus.req_error = err_q;
      bus.command_valid = st == SEND;
      bus.command_byte = st == SEND ? (k ? b1 : b0) : 8'h00;
      bus.command_ack_ready = st == LINE_ACK;
      bus.busy = st != IDLE;
   end
endmodule
